// File: rtl/ecg_class_uart_tx.sv
// ecg_class_uart_tx: buffers 3-bit class results, sends each as ASCII digit + LF over UART (ECG_UART_PARITY_EN adds even parity)
module ecg_class_uart_tx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] class_in,
    input  logic       class_valid,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_CLK = BW'(CLKS_PER_BIT - 1);

`ifdef ECG_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [2:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            lf_q, lf_d, tx_q, tx_d, busy_q, busy_d, ovf_q, ovf_d;
    logic            pop, push, bit_end;

    // a full FIFO still accepts when the head leaves on the same edge
    assign pop     = state_q == IDLE && cnt_q != '0;
    assign push    = class_valid && (cnt_q != FULL_CNT || pop);
    assign bit_end = baud_q == LAST_CLK;

    always_comb begin
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
        ovf_d   = ovf_q | (class_valid & ~push);
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        lf_d    = lf_q;
        busy_d  = busy_q;
        if (state_q == IDLE) begin
            busy_d = pop;
            if (pop) begin
                data_d  = {5'b00110, mem_q[rd_q]};
                lf_d    = 1'b0;
                baud_d  = '0;
                bit_d   = '0;
                state_d = START;
            end
        end else begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
            if (bit_end) begin
                unique case (state_q)
                    START: begin
                        bit_d   = '0;
                        state_d = DATA;
                    end
                    DATA: begin
                        bit_d = bit_q + 1'b1;
`ifdef ECG_UART_PARITY_EN
                        state_d = bit_q == 3'd7 ? PARITY : DATA;
                    end
                    PARITY: state_d = STOP;
`else
                        state_d = bit_q == 3'd7 ? STOP : DATA;
                    end
`endif
                    STOP: begin
                        data_d  = lf_q ? data_q : 8'h0A;
                        lf_d    = 1'b1;
                        busy_d  = !lf_q;
                        state_d = lf_q ? IDLE : START;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
`ifdef ECG_UART_PARITY_EN
        tx_d = state_q == START  ? 1'b0 :
               state_q == DATA   ? data_q[bit_q] :
               state_q == PARITY ? ^data_q : 1'b1;
`else
        tx_d = state_q == START ? 1'b0 :
               state_q == DATA  ? data_q[bit_q] : 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= class_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            lf_q    <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            lf_q    <= lf_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign fifo_full = cnt_q == FULL_CNT;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_ecg_class_uart_tx.sv
// tb_ecg_class_uart_tx: directed vectors for ecg_class_uart_tx with a UART line decoder
module tb_ecg_class_uart_tx;
    localparam int CF  = 1000;
    localparam int BR  = 125;
    localparam int CPB = CF / BR;
`ifdef ECG_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int PAIR = 2 * NB * CPB;
    localparam int LIM  = 20 * PAIR;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] class_in;
    logic       class_valid;
    logic       tx, busy, fifo_full, overflow;

    ecg_class_uart_tx #(.CLK_FREQ(CF), .BAUD(BR), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .class_in(class_in), .class_valid(class_valid),
        .tx(tx), .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rst_ev = 0;
    int framing_bad = 0;
    int rise_c = 0;
    int fall_c = 0;
    logic busy_p = 1'b0;
    logic [7:0] bytes [$];
    logic       pars [$];
    int         falls [$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) rst_ev <= rst_ev + 1;
    always @(negedge clk) begin
        busy_p <= busy;
        if (busy && !busy_p) rise_c <= cyc;
        if (!busy && busy_p) fall_c <= cyc;
    end

    // line decoder: samples mid-bit, drops frames cut short by reset
    logic [7:0] mb;
    logic       mp, mst, msp;
    int         mev;
    initial begin
        forever begin
            @(negedge tx);
            if (rst_n) begin
                mev = rst_ev;
                mb  = '0;
                mp  = 1'b0;
                @(negedge clk);
                falls.push_back(cyc);
                repeat (CPB / 2 - 1) @(negedge clk);
                mst = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mb[i] = tx;
                end
`ifdef ECG_UART_PARITY_EN
                repeat (CPB) @(negedge clk);
                mp = tx;
`endif
                repeat (CPB) @(negedge clk);
                msp = tx;
                if (mev == rst_ev) begin
                    bytes.push_back(mb);
                    pars.push_back(mp);
                    if (mst !== 1'b0 || msp !== 1'b1) framing_bad++;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp_v, exp_v);
        end
    endtask

    task automatic clear_q;
        bytes.delete();
        pars.delete();
        falls.delete();
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while ((busy || bytes.size() < n) && k < LIM) begin
            @(negedge clk);
            k++;
        end
        chk("wait_bound", int'(k < LIM), 1);
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic [2:0] cls;
        logic [7:0] chr;
        logic       par;
    } vec_t;
    vec_t vecs [5];

    initial begin
        int ce;
        logic seen;
        vecs[0] = '{3'd3, 8'h33, 1'b0};
        vecs[1] = '{3'd6, 8'h36, 1'b0};
        vecs[2] = '{3'd1, 8'h31, 1'b1};
        vecs[3] = '{3'd0, 8'h30, 1'b0};
        vecs[4] = '{3'd7, 8'h37, 1'b1};
        rst_n = 1'b0;
        class_valid = 1'b0;
        class_in = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_full", fifo_full, 0);
        chk("reset_ovf", overflow, 0);

        // single results
        for (int v = 0; v < 5; v++) begin
            clear_q();
            class_in = vecs[v].cls;
            class_valid = 1'b1;
            ce = cyc + 1;
            @(negedge clk);
            class_valid = 1'b0;
            chk("lat_busy_e", busy, 0);
            chk("lat_tx_e", tx, 1);
            @(negedge clk);
            chk("lat_busy_e1", busy, 1);
            chk("lat_tx_e1", tx, 1);
            @(negedge clk);
            chk("lat_tx_e2", tx, 0);
            wait_done(2);
            chk("single_count", bytes.size(), 2);
            chk("single_digit", bytes[0], vecs[v].chr);
            chk("single_lf", bytes[1], 8'h0A);
            chk("single_fall0", falls[0], ce + 2);
            chk("single_fall1", falls[1], ce + 2 + NB * CPB);
            chk("single_busy_len", fall_c - rise_c, PAIR);
            chk("single_tx_end", tx, 1);
`ifdef ECG_UART_PARITY_EN
            chk("parity_digit", pars[0], vecs[v].par);
            chk("parity_lf", pars[1], 0);
`endif
        end
        chk("framing_single", framing_bad, 0);

        // burst of six: '0' popped at once, 1..4 fill the FIFO, 5 dropped
        clear_q();
        for (int v = 0; v < 6; v++) begin
            class_in = 3'(v);
            class_valid = 1'b1;
            @(negedge clk);
            if (v == 4) begin
                chk("burst_full_e4", fifo_full, 1);
                chk("burst_ovf_e4", overflow, 0);
            end
        end
        class_valid = 1'b0;
        chk("burst_full_e5", fifo_full, 1);
        chk("burst_ovf_e5", overflow, 1);
        wait_done(10);
        chk("burst_count", bytes.size(), 10);
        for (int i = 0; i < 5; i++) begin
            chk("burst_digit", bytes[2 * i], 8'h30 + i);
            chk("burst_lf", bytes[2 * i + 1], 8'h0A);
        end
        chk("burst_gap", falls[2] - falls[1], NB * CPB + 1);
        chk("burst_full_end", fifo_full, 0);
        chk("burst_ovf_sticky", overflow, 1);
        do_reset();
        chk("ovf_cleared", overflow, 0);

        // back-to-back: second result arrives mid-frame
        clear_q();
        class_in = 3'd2;
        class_valid = 1'b1;
        @(negedge clk);
        class_valid = 1'b0;
        repeat (99) @(negedge clk);
        class_in = 3'd7;
        class_valid = 1'b1;
        @(negedge clk);
        class_valid = 1'b0;
        wait_done(4);
        chk("b2b_count", bytes.size(), 4);
        chk("b2b_b0", bytes[0], 8'h32);
        chk("b2b_b1", bytes[1], 8'h0A);
        chk("b2b_b2", bytes[2], 8'h37);
        chk("b2b_b3", bytes[3], 8'h0A);
        chk("b2b_lf_gap", falls[1] - falls[0], NB * CPB);
        chk("b2b_pair_gap", falls[2] - falls[1], NB * CPB + 1);

        // full FIFO with a strobe on the pop edge
        clear_q();
        ce = cyc + 1;
        for (int v = 1; v < 6; v++) begin
            class_in = 3'(v);
            class_valid = 1'b1;
            @(negedge clk);
        end
        class_valid = 1'b0;
        chk("fsp_full", fifo_full, 1);
        chk("fsp_ovf_pre", overflow, 0);
        begin
            int k = 0;
            while (busy && k < LIM) begin
                @(negedge clk);
                k++;
            end
        end
        chk("fsp_idle_cycle", cyc, ce + 1 + PAIR);
        class_in = 3'd6;
        class_valid = 1'b1;
        @(negedge clk);
        class_valid = 1'b0;
        chk("fsp_ovf_post", overflow, 0);
        chk("fsp_full_post", fifo_full, 1);
        chk("fsp_busy_post", busy, 1);
        wait_done(12);
        chk("fsp_count", bytes.size(), 12);
        for (int i = 0; i < 6; i++) begin
            chk("fsp_digit", bytes[2 * i], 8'h31 + i);
            chk("fsp_lf", bytes[2 * i + 1], 8'h0A);
        end
        chk("framing_multi", framing_bad, 0);

        // reset during the digit's data bits, FIFO still holding an entry
        clear_q();
        class_in = 3'd5;
        class_valid = 1'b1;
        @(negedge clk);
        class_in = 3'd6;
        @(negedge clk);
        class_valid = 1'b0;
        repeat (1 + 2 * CPB + CPB / 2) @(negedge clk);
        chk("rst_mid_tx_pre", tx, 0);
        chk("rst_mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_full", fifo_full, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        seen = 1'b0;
        repeat (3 * PAIR) begin
            @(negedge clk);
            if (busy || !tx) seen = 1'b1;
        end
        chk("rst_quiet", seen, 0);
        chk("rst_no_frames", falls.size(), 0);
        chk("rst_ovf", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ecg_class_uart_tx.md
Name: ecg_class_uart_tx

Overview:
- Consumer end of the ECG_Top classification result interface.
- Captures each 3-bit class result on a valid strobe and buffers it in a small FIFO.
- Serialises each result over a UART TX line as one ASCII digit followed by a line feed, for host-side logging of the accelerator's decisions.
- Sits beside ECG_Top at chip top level and drives the debug/host UART pin.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (434), clocks per UART bit. Integer division, truncated.
- FIFO_DEPTH, 4, result buffer entries. Power of two, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- class_in  input  3  classification result from ECG_Top.
- class_valid  input  1  single-cycle strobe: class_in is valid this cycle.
- tx  output  1  UART serial out. Idle high.
- busy  output  1  high while a result frame pair is being transmitted.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- overflow  output  1  sticky flag: a result was dropped.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - tx=1, busy=0, fifo_full=0, overflow=0.
  - FIFO empty; FSM in IDLE; bit counter and baud counter zero.
  - Assertion mid-frame forces tx high immediately, asynchronously. The partial frame is abandoned; no resume after release.
- FIFO push: on a clk edge with class_valid=1, class_in is written if count<FIFO_DEPTH, or if a pop occurs on the same edge.
- FIFO full: if full and no simultaneous pop, the value is dropped and overflow is set to 1. It stays 1 until reset.
- fifo_full reflects count==FIFO_DEPTH after each edge. Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - A byte-select flag chooses the character byte {5'b00110, class} (0x30..0x37) or LF (0x0A).
- IDLE:
  - If FIFO not empty: pop the head into the shift register as an ASCII digit, clear the byte select, set busy=1, go to START.
  - Otherwise tx=1, busy=0.
- START: tx=0 for CLKS_PER_BIT clocks, then DATA.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT clocks. The bit index counts 0..7, then the FSM goes to STOP (or PARITY).
- STOP: tx=1 for CLKS_PER_BIT clocks.
  - If the byte select indicates the digit byte: load 0x0A, set the byte select, go to START directly (no idle gap).
  - Otherwise go to IDLE and clear busy on the same edge.
- IDLE may pop a new entry on the first cycle after returning.
- Latency: from idle with an empty FIFO, class_valid sampled at edge E causes the push at E, the pop at E+1, and tx falling at edge E+2.
- Frame pair duration: 2*10*CLKS_PER_BIT clocks = 8680 at defaults (22 bits with parity).
- class_valid is ignored for transmission purposes while low; class_in is don't-care then.

Optional Feature:
- Macro: ECG_UART_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP. It drives the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT clocks. Frame becomes 11 bits.
- When undefined: no PARITY state or parity logic exists; frame is 10 bits (8N1).

Test Plan:
- Single result: reset, then class_in=3 with class_valid=1 for one cycle → tx falls 2 clocks later. Decoded bytes are 0x33 then 0x0A, each bit 434 clocks. busy is high for 8680 clocks, then 0; tx ends high.
- Burst: class_valid=1 on 6 consecutive cycles with values 0..5 → bytes '0','1','2','3','4' each followed by 0x0A are sent. Value 5 is dropped; overflow=1 and fifo_full=1 after the 6th edge.
- Back-to-back: push 2 then 7 spaced 100 clocks apart → frames 0x32,0x0A,0x37,0x0A are contiguous, with no idle bits between the first LF stop bit and the second start bit.
- Full with simultaneous pop: fill FIFO to 4 while a frame is in progress. Strobe class_valid exactly on the cycle IDLE pops → the value is accepted and overflow stays 0.
- Reset mid-frame: assert rst_n=0 during DATA of the digit byte → tx=1 and busy=0 immediately, FIFO empty. After release, no further frames occur without a new strobe.
- Parity (ECG_UART_PARITY_EN defined): class_in=6 → byte 0x36 (four ones) produces parity bit 0; LF 0x0A produces parity bit 0. Then class_in=1 → 0x31 (three ones) produces parity bit 1. busy lasts 2*11*434=9548 clocks.
